// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and helpers for the store-and-forward AXI-stream packet FIFO.
package axis_pkt_fifo_pkg;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    // Address width that stays at least one bit for tiny depths
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module axis_pkt_fifo_mem
    import axis_pkt_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 257,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-stream packet FIFO with FWFT output.
// Define AXIS_PKT_FIFO_DROP_EN to drop overflowing packets instead of back-pressuring.
module axis_pkt_fifo
    import axis_pkt_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned AW        = addr_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [AW:0]           pkt_count
`ifdef AXIS_PKT_FIFO_DROP_EN
    ,
    output logic                  pkt_drop
`endif
);

    localparam int unsigned WW      = DATA_WIDTH + 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   used;
    logic          full;
    logic          empty;
    logic          wr_fire;
    logic          rd_fire;
    logic          rd_last;
    logic          mem_we;
    logic          pkt_inc;
    logic [WW-1:0] rd_word;

    assign used    = wr_ptr - rd_ptr;
    assign full    = (used == DEPTH_W);
    assign empty   = (used == '0);
    assign wr_fire = s_axis_tvalid & s_axis_tready;
    assign rd_fire = m_axis_tvalid & m_axis_tready;
    assign rd_last = rd_fire & m_axis_tlast;

    assign {m_axis_tdata, m_axis_tlast} = rd_word;

    axis_pkt_fifo_mem #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({s_axis_tdata, s_axis_tlast}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_word)
    );

`ifdef AXIS_PKT_FIFO_DROP_EN
    state_t      state;
    logic [AW:0] wr_commit;

    assign s_axis_tready = ~rst;
    assign m_axis_tvalid = ~empty & (pkt_count != '0);
    assign mem_we        = wr_fire & (state == ST_PASS) & ~full;
    assign pkt_inc       = mem_we & s_axis_tlast;

    // Write side: an overflowing packet rewinds to its start and is discarded up to tlast
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            wr_commit <= '0;
            state     <= ST_PASS;
            pkt_drop  <= 1'b0;
        end else begin
            pkt_drop <= 1'b0;
            if (wr_fire) begin
                case (state)
                    ST_PASS: begin
                        if (!full) begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                            if (s_axis_tlast) begin
                                wr_commit <= wr_ptr + PTR_ONE;
                            end
                        end else begin
                            wr_ptr <= wr_commit;
                            if (s_axis_tlast) begin
                                pkt_drop <= 1'b1;
                            end else begin
                                state <= ST_DROP;
                            end
                        end
                    end
                    ST_DROP: begin
                        if (s_axis_tlast) begin
                            state    <= ST_PASS;
                            pkt_drop <= 1'b1;
                        end
                    end
                    default: state <= ST_PASS;
                endcase
            end
        end
    end
`else
    logic cut_thru;

    assign s_axis_tready = ~full & ~rst;
    assign m_axis_tvalid = ~empty & ((pkt_count != '0) | cut_thru);
    assign mem_we        = wr_fire;
    assign pkt_inc       = wr_fire & s_axis_tlast;

    // cut_thru lets a packet longer than the FIFO stream through instead of deadlocking
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            cut_thru <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_last) begin
                cut_thru <= 1'b0;
            end else if (full && (pkt_count == '0)) begin
                cut_thru <= 1'b1;
            end
        end
    end
`endif

    // Read pointer and complete-packet count
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            pkt_count <= '0;
        end else begin
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (pkt_inc && !rd_last) begin
                pkt_count <= pkt_count + PTR_ONE;
            end else if (!pkt_inc && rd_last) begin
                pkt_count <= pkt_count - PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo: directed packets plus random traffic vs a queue model.
module tb_axis_pkt_fifo;

    localparam int unsigned DW    = 256;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic [AW:0]   pkt_count;
`ifdef AXIS_PKT_FIFO_DROP_EN
    logic          pkt_drop;
`endif

    always #5 clk = ~clk;

    axis_pkt_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_count     (pkt_count)
`ifdef AXIS_PKT_FIFO_DROP_EN
        ,
        .pkt_drop      (pkt_drop)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    // Reference model: the stored words in order, plus escape/drop status
    word_t q[$];
    bit    cut;
    bit    in_drop;
    bit    exp_drop;
    int    n_tests;
    int    n_fail;

    function automatic int n_pkts();
        int c = 0;
        foreach (q[i]) if (q[i].l) c++;
        return c;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance the model
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l,
                        input logic mr, input logic r, output logic acc);
        bit full, exp_sr, exp_mv, rd, rdl;
        @(negedge clk);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        m_axis_tready = mr;
        rst           = r;
        #1;
        full = (q.size() == DEPTH);
`ifdef AXIS_PKT_FIFO_DROP_EN
        exp_sr = !r;
`else
        exp_sr = !full && !r;
`endif
        exp_mv = (q.size() != 0) && ((n_pkts() != 0) || cut);
        check("s_tready", DW'(s_axis_tready), DW'(exp_sr));
        check("m_tvalid", DW'(m_axis_tvalid), DW'(exp_mv));
        check("pkt_count", DW'(pkt_count), DW'(n_pkts()));
        if (exp_mv && m_axis_tvalid) begin
            check("m_tdata", m_axis_tdata, q[0].d);
            check("m_tlast", DW'(m_axis_tlast), DW'(q[0].l));
        end
`ifdef AXIS_PKT_FIFO_DROP_EN
        check("pkt_drop", DW'(pkt_drop), DW'(exp_drop));
`endif
        acc = v && exp_sr;
        exp_drop = 0;
        if (r) begin
            q.delete();
            cut     = 0;
            in_drop = 0;
        end else begin
            rd  = exp_mv && mr;
            rdl = rd && q[0].l;
`ifndef AXIS_PKT_FIFO_DROP_EN
            if (rdl) cut = 0;
            else if (full && n_pkts() == 0) cut = 1;
`endif
            if (rd) void'(q.pop_front());
`ifdef AXIS_PKT_FIFO_DROP_EN
            if (acc) begin
                if (in_drop) begin
                    if (l) begin
                        in_drop  = 0;
                        exp_drop = 1;
                    end
                end else if (full) begin
                    while (q.size() != 0 && !q[q.size()-1].l) void'(q.pop_back());
                    if (l) exp_drop = 1;
                    else in_drop = 1;
                end else begin
                    q.push_back(word_t'{d: d, l: l});
                end
            end
`else
            if (acc) q.push_back(word_t'{d: d, l: l});
`endif
        end
    endtask

    task automatic send_pkt(input int n, input int base, input logic mr, input bit with_last);
        logic acc;
        int   tries;
        for (int i = 0; i < n; i++) begin
            acc   = 1'b0;
            tries = 0;
            while (!acc && tries < 200) begin
                step(1'b1, DW'(base + i), with_last && (i == n - 1), mr, 1'b0, acc);
                tries++;
            end
            if (!acc) begin
                check("send_timeout", DW'(acc), DW'(1));
                return;
            end
        end
    endtask

    task automatic idle(input int n, input logic mr);
        logic acc;
        repeat (n) step(1'b0, '0, 1'b0, mr, 1'b0, acc);
    endtask

    initial begin
        logic          acc;
        logic          v;
        logic          mr;
        logic          r;
        logic [DW-1:0] d;
        int            rem;

        n_tests = 0;
        n_fail  = 0;
        cut     = 0;
        in_drop = 0;
        exp_drop = 0;
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);

        // Reset state, then a 4-word packet and a single-word packet
        idle(2, 1'b1);
        send_pkt(4, 1, 1'b1, 1'b1);
        idle(6, 1'b1);
        step(1'b1, DW'(8'hAA), 1'b1, 1'b0, 1'b0, acc);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Fill to 16 words with the sink stalled, then free one slot
        send_pkt(5, 16'h100, 1'b0, 1'b1);
        send_pkt(5, 16'h200, 1'b0, 1'b1);
        send_pkt(5, 16'h300, 1'b0, 1'b1);
        send_pkt(1, 16'h400, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        send_pkt(1, 16'h401, 1'b1, 1'b1);
        idle(20, 1'b1);

        // Packet longer than the FIFO
        send_pkt(20, 16'h500, 1'b1, 1'b1);
        idle(20, 1'b1);

`ifdef AXIS_PKT_FIFO_DROP_EN
        // Second packet overflows while the sink is stalled and is dropped
        send_pkt(10, 16'h600, 1'b0, 1'b1);
        send_pkt(10, 16'h700, 1'b0, 1'b1);
        idle(3, 1'b0);
        idle(15, 1'b1);
`endif

        // Reset in the middle of a packet, then a clean packet
        send_pkt(3, 16'h800, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
        idle(2, 1'b1);
        send_pkt(6, 16'h900, 1'b1, 1'b1);
        idle(10, 1'b1);

        // Random traffic: mixed packet lengths, gaps, sink stalls and rare resets
        rem = 0;
        for (int c = 0; c < 4000; c++) begin
            if (rem == 0) begin
                rem = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 24))
                                                  : int'($urandom_range(1, 8));
            end
            v  = ($urandom_range(0, 3) != 0);
            mr = ((c / 500) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 399) == 0);
            d  = {8{$urandom()}};
            step(v, d, rem == 1, mr, r, acc);
            if (r) rem = 0;
            else if (acc) rem--;
        end
        idle(60, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
